mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised MEM-stage load/store controller for the xSoc CPU pipeline. It sits between the EX/MEM pipeline register and the memory bus. It supports byte, halfword, word and (for 64-bit data) doubleword accesses, with sign or zero extension and active-low byte-lane enables. Each access runs a multi-cycle bus handshake with wait states and a timeout. While an access is in flight the block stalls the pipeline, and it flags misaligned or illegal operations without touching the bus.

## Interface
- DATA_W, 32, bus/data width; legal values 32 or 64. LANES = DATA_W/8; OFF_W = log2(LANES).
- ADDR_W, 32, byte-address width; must be ≤ DATA_W.
- TIMEOUT, 16, wait cycles allowed before a bus error; 0 disables the timeout; max 255.

Ports:
- clk  in  1  clock, all state on rising edge
- reset_  in  1  asynchronous, active-low reset
- ex_en  in  1  EX/MEM stage valid
- ex_mem_op  in  5  [4]=access, [3]=write, [2]=unsigned (loads only), [1:0]=size (0 B, 1 H, 2 W, 3 D)
- ex_mem_wr_data  in  DATA_W  store data, right-aligned
- ex_out  in  DATA_W  ALU result; byte address = ex_out[ADDR_W-1:0]
- rd_data  in  DATA_W  bus read data
- rdy_  in  1  bus ready, active-low
- addr  out  ADDR_W-OFF_W  bus word address
- as_  out  1  address strobe, active-low
- rw  out  1  1=read, 0=write
- be_  out  LANES  byte enables, active-low
- wr_data  out  DATA_W  lane-replicated store data
- out  out  DATA_W  MEM result
- miss_align  out  1  misaligned or illegal op (combinational)
- bus_err  out  1  timeout pulse, one cycle
- done  out  1  access-complete pulse, one cycle
- stall  out  1  pipeline hold request (combinational)

## Operation
- States: IDLE, ACCESS, DONE.
- A request is defined as ex_en=1 with ex_mem_op[4]=1.
- Legality rules:
  - Size 3 with DATA_W=32 is illegal.
  - An access is misaligned when addr[size-1:0] ≠ 0, using the byte offset within the word.
  - For an illegal or misaligned request in IDLE, miss_align=1 that cycle, there is no bus activity, stall=0, out=0, and the state stays IDLE.
- Legal request in IDLE:
  - stall=1.
  - On the next edge: ACCESS, as_=0; addr = address[ADDR_W-1:OFF_W]; rw = ~write.
  - be_ clears the lanes [offset, offset+2^size-1].
  - wr_data replicates the low 2^size bytes of ex_mem_wr_data across all lanes.
  - Offset, size and unsigned are registered.
- ACCESS:
  - stall=1 and the bus outputs are held.
  - The wait counter increments each cycle.
  - If rdy_=0: on the next edge go to DONE, as_=1, be_=all 1s. For reads, the selected lanes of rd_data are extracted and sign- or zero-extended to DATA_W into the load register. For writes, the load register is cleared.
  - Otherwise, if TIMEOUT≠0 and the counter equals TIMEOUT-1: on the next edge go to DONE with bus_err=1, as_=1, and the load register cleared.
  - rdy_ takes priority over the timeout in the same cycle.
- DONE:
  - done=1 and stall=0; out = load register.
  - Inputs are ignored because they still hold the completed op, so nothing is re-issued.
  - Next edge: IDLE.
- Non-memory op in IDLE (ex_en=1, op[4]=0): out = ex_out pass-through, stall=0.
- ex_en=0 in IDLE: out=0, stall=0.
- Unsigned flag on stores is ignored. A doubleword load ignores the unsigned flag.
- reset_ low at any time, including mid-ACCESS, forces IDLE immediately:
  - as_=1, rw=1, addr=0, be_=all 1s, wr_data=0.
  - Load register=0, counter=0.
  - bus_err=0, done=0, stall=0, miss_align=0.

## Timing
- Best-case load/store with rdy_ low on the first ACCESS cycle: request in cycle T, as_ low in T+1, DONE in T+2. Total 3 cycles, stall high in T and T+1.
- Each wait cycle (rdy_ high) adds 1 cycle of latency.
- A timeout gives DONE exactly TIMEOUT cycles after entering ACCESS.
- rdy_ is sampled only in ACCESS. rdy_ low in IDLE or DONE is ignored.
- Bus outputs are registered. miss_align, stall and out are combinational from state and inputs.
- Back-to-back accesses always have a single DONE cycle between them (throughput of one access per 3+ cycles).

## Test plan
- DATA_W=32, LB at 0x1003, rd_data=0x80_00_00_00, rdy_ low immediately -> be_=4'b0111; out=0xFFFF_FF80 in DONE; done=1 for one cycle; stall high for 2 cycles.
- SH at 0x2002, wr_data=0x0000_ABCD, rdy_ low after 3 wait cycles -> addr=0x800, rw=0, be_=4'b0011, wr_data=0xABCD_ABCD, as_ low 4 cycles, stall high 5 cycles.
- LW at 0x1001 -> miss_align=1 the same cycle, as_ stays 1, stall=0, out=0. With DATA_W=32, op size 3 -> miss_align=1.
- TIMEOUT=4, LW with rdy_ held high -> as_ low 4 cycles, then bus_err=1 and done=1 for one cycle, out=0.
- DATA_W=64: LHU at 0x...6, rd_data lane bytes 7:6 = 0xBEEF -> be_=8'b0011_1111, out=0x0000_0000_0000_BEEF. SD at 0x...8 -> be_=0x00.
- Assert reset_ in the second ACCESS cycle -> as_=1 asynchronously, all outputs at reset values; after release a new LW completes normally. Non-mem op with ex_out=0x1234 -> out=0x1234, stall=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: decodes the EX/MEM request, runs a
// registered bus handshake with wait states and timeout, and returns load data.
`timescale 1ns/1ps
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16,
  localparam int LANES  = DATA_W / 8,
  localparam int OFF_W  = $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    reset_,
  input  logic                    ex_en,
  input  logic [4:0]              ex_mem_op,
  input  logic [DATA_W-1:0]       ex_mem_wr_data,
  input  logic [DATA_W-1:0]       ex_out,
  input  logic [DATA_W-1:0]       rd_data,
  input  logic                    rdy_,
  output logic [ADDR_W-OFF_W-1:0] addr,
  output logic                    as_,
  output logic                    rw,
  output logic [LANES-1:0]        be_,
  output logic [DATA_W-1:0]       wr_data,
  output logic [DATA_W-1:0]       out,
  output logic                    miss_align,
  output logic                    bus_err,
  output logic                    done,
  output logic                    stall
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  function automatic logic op_illegal(input logic [OFF_W-1:0] off,
                                      input logic [1:0]       size);
    logic [OFF_W-1:0] m;
    if (size == 2'd3 && DATA_W == 32) return 1'b1;
    m = OFF_W'((1 << size) - 1);
    return |(off & m);
  endfunction

  function automatic logic [LANES-1:0] lane_mask(input logic [OFF_W-1:0] off,
                                                 input logic [1:0]       size);
    logic [LANES-1:0] m;
    int nb;
    nb = 1 << size;
    for (int i = 0; i < LANES; i++)
      m[i] = (i >= int'(off)) && (i < int'(off) + nb);
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] lane_replicate(input logic [DATA_W-1:0] d,
                                                       input logic [1:0]        size);
    logic [DATA_W-1:0] r;
    int nb;
    nb = 1 << size;
    r  = '0;
    for (int i = 0; i < LANES; i++)
      r[8*i +: 8] = d[8*(i % nb) +: 8];
    return r;
  endfunction

  // Doubleword loads already fill the word, so the unsigned flag has no effect there.
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] rd,
                                                    input logic [OFF_W-1:0]  off,
                                                    input logic [1:0]        size,
                                                    input logic              uns);
    logic [DATA_W-1:0]        sh;
    logic signed [DATA_W-1:0] s;
    logic signed [7:0]        b;
    logic signed [15:0]       h;
    logic signed [31:0]       w;
    sh = rd >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    w  = sh[31:0];
    s  = '0;
    case (size)
      2'd0:    if (uns) s[7:0]  = sh[7:0];  else s = b;
      2'd1:    if (uns) s[15:0] = sh[15:0]; else s = h;
      2'd2:    if (uns) s[31:0] = sh[31:0]; else s = w;
      default: s = sh;
    endcase
    return s;
  endfunction

  logic [ADDR_W-1:0]       baddr_p0;
  logic [OFF_W-1:0]        off_p0;
  logic [1:0]              size_p0;
  logic                    req_p0;
  logic                    bad_p0;
  logic                    issue_p0;
  logic                    tmo_hit_p1;

  logic [1:0]              state_p1;
  logic [ADDR_W-OFF_W-1:0] addr_p1;
  logic                    as_p1;
  logic                    rw_p1;
  logic [LANES-1:0]        be_p1;
  logic [DATA_W-1:0]       wr_data_p1;
  logic [DATA_W-1:0]       load_p1;
  logic [7:0]              cnt_p1;
  logic [OFF_W-1:0]        off_p1;
  logic [1:0]              size_p1;
  logic                    uns_p1;
  logic                    berr_p1;

  // Request decode, straight from the EX/MEM register
  assign baddr_p0   = ex_out[ADDR_W-1:0];
  assign off_p0     = baddr_p0[OFF_W-1:0];
  assign size_p0    = ex_mem_op[1:0];
  assign req_p0     = ex_en & ex_mem_op[4];
  assign bad_p0     = op_illegal(off_p0, size_p0);
  assign issue_p0   = req_p0 & ~bad_p0;
  assign tmo_hit_p1 = (TIMEOUT != 0) && (cnt_p1 == TO_LAST);

  // Bus stage: all bus-facing outputs come from these registers
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_p1   <= ST_IDLE;
      addr_p1    <= '0;
      as_p1      <= 1'b1;
      rw_p1      <= 1'b1;
      be_p1      <= '1;
      wr_data_p1 <= '0;
      load_p1    <= '0;
      cnt_p1     <= '0;
      off_p1     <= '0;
      size_p1    <= '0;
      uns_p1     <= 1'b0;
      berr_p1    <= 1'b0;
    end else begin
      case (state_p1)
        ST_IDLE: begin
          berr_p1 <= 1'b0;
          if (issue_p0) begin
            state_p1   <= ST_ACCESS;
            addr_p1    <= baddr_p0[ADDR_W-1:OFF_W];
            as_p1      <= 1'b0;
            rw_p1      <= ~ex_mem_op[3];
            be_p1      <= ~lane_mask(off_p0, size_p0);
            wr_data_p1 <= lane_replicate(ex_mem_wr_data, size_p0);
            off_p1     <= off_p0;
            size_p1    <= size_p0;
            uns_p1     <= ex_mem_op[2];
            cnt_p1     <= '0;
          end
        end
        ST_ACCESS: begin
          if (!rdy_) begin
            state_p1 <= ST_DONE;
            as_p1    <= 1'b1;
            be_p1    <= '1;
            load_p1  <= rw_p1 ? load_extend(rd_data, off_p1, size_p1, uns_p1) : '0;
          end else if (tmo_hit_p1) begin
            state_p1 <= ST_DONE;
            as_p1    <= 1'b1;
            be_p1    <= '1;
            load_p1  <= '0;
            berr_p1  <= 1'b1;
          end else begin
            cnt_p1 <= cnt_p1 + 8'd1;
          end
        end
        ST_DONE: begin
          state_p1 <= ST_IDLE;
          berr_p1  <= 1'b0;
        end
        default: state_p1 <= ST_IDLE;
      endcase
    end
  end

  // Result / hold stage; reset_ gating keeps the flags quiet while reset is held
  always_comb begin
    miss_align = 1'b0;
    stall      = 1'b0;
    out        = '0;
    case (state_p1)
      ST_IDLE: begin
        miss_align = reset_ & req_p0 & bad_p0;
        stall      = reset_ & issue_p0;
        if (ex_en && !ex_mem_op[4]) out = ex_out;
      end
      ST_ACCESS: stall = 1'b1;
      ST_DONE:   out   = load_p1;
      default:   ;
    endcase
  end

  assign addr    = addr_p1;
  assign as_     = as_p1;
  assign rw      = rw_p1;
  assign be_     = be_p1;
  assign wr_data = wr_data_p1;
  assign bus_err = berr_p1;
  assign done    = (state_p1 == ST_DONE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 32-bit/TIMEOUT=4 instance and a 64-bit instance,
// checked every cycle against a transaction-level model plus literal expectations.
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset_;
  always #5 clk = ~clk;

  logic        i_en  [2];
  logic [4:0]  i_op  [2];
  logic [63:0] i_wd  [2];
  logic [63:0] i_exo [2];
  logic [63:0] i_rd  [2];
  logic        i_rdy [2];

  logic [29:0] a_addr;  logic a_as, a_rw, a_mis, a_berr, a_done, a_stall;
  logic [3:0]  a_be;    logic [31:0] a_wr, a_out;
  logic [28:0] b_addr;  logic b_as, b_rw, b_mis, b_berr, b_done, b_stall;
  logic [7:0]  b_be;    logic [63:0] b_wr, b_out;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut_a (
    .clk(clk), .reset_(reset_), .ex_en(i_en[0]), .ex_mem_op(i_op[0]),
    .ex_mem_wr_data(i_wd[0][31:0]), .ex_out(i_exo[0][31:0]), .rd_data(i_rd[0][31:0]),
    .rdy_(i_rdy[0]), .addr(a_addr), .as_(a_as), .rw(a_rw), .be_(a_be), .wr_data(a_wr),
    .out(a_out), .miss_align(a_mis), .bus_err(a_berr), .done(a_done), .stall(a_stall));

  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(16)) dut_b (
    .clk(clk), .reset_(reset_), .ex_en(i_en[1]), .ex_mem_op(i_op[1]),
    .ex_mem_wr_data(i_wd[1]), .ex_out(i_exo[1]), .rd_data(i_rd[1]),
    .rdy_(i_rdy[1]), .addr(b_addr), .as_(b_as), .rw(b_rw), .be_(b_be), .wr_data(b_wr),
    .out(b_out), .miss_align(b_mis), .bus_err(b_berr), .done(b_done), .stall(b_stall));

  logic [63:0] o_addr [2], o_wr [2], o_out [2];
  logic [7:0]  o_be   [2];
  logic        o_as [2], o_rw [2], o_mis [2], o_berr [2], o_done [2], o_stall [2];

  always_comb begin
    o_addr[0] = 64'(a_addr); o_addr[1] = 64'(b_addr);
    o_wr[0]   = 64'(a_wr);   o_wr[1]   = b_wr;
    o_out[0]  = 64'(a_out);  o_out[1]  = b_out;
    o_be[0]   = 8'(a_be);    o_be[1]   = b_be;
    o_as[0]   = a_as;        o_as[1]   = b_as;
    o_rw[0]   = a_rw;        o_rw[1]   = b_rw;
    o_mis[0]  = a_mis;       o_mis[1]  = b_mis;
    o_berr[0] = a_berr;      o_berr[1] = b_berr;
    o_done[0] = a_done;      o_done[1] = b_done;
    o_stall[0]= a_stall;     o_stall[1]= b_stall;
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;
  int n_as [2], n_stall [2], n_done [2];

  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, i, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int lanes(input int i);   return (i != 0) ? 8 : 4;  endfunction
  function automatic int tmo(input int i);     return (i != 0) ? 16 : 4; endfunction
  function automatic logic [63:0] dwmask(input int i);
    return (i != 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic bit illegal_req(input int i, input logic [63:0] exo, input logic [4:0] op);
    int off, sz;
    sz  = int'(op[1:0]);
    off = int'(exo[2:0]) & (lanes(i) - 1);
    return (sz == 3 && lanes(i) == 4) || ((off % (1 << sz)) != 0);
  endfunction

  int          m_ph [2], m_cnt [2], m_off [2], m_size [2];
  logic [63:0] m_addr [2], m_wr [2], m_load [2];
  logic [7:0]  m_be [2];
  logic        m_as [2], m_rw [2], m_berr [2], m_uns [2];

  task automatic model_reset(input int i);
    m_ph[i] = 0; m_cnt[i] = 0; m_off[i] = 0; m_size[i] = 0;
    m_addr[i] = '0; m_wr[i] = '0; m_load[i] = '0;
    m_be[i] = 8'((64'd1 << lanes(i)) - 1);
    m_as[i] = 1'b1; m_rw[i] = 1'b1; m_berr[i] = 1'b0; m_uns[i] = 1'b0;
  endtask

  task automatic model_step(input int i);
    int nl, nb, off, sz;
    logic [63:0] mask, v;
    nl = lanes(i);
    case (m_ph[i])
      0: begin
        m_berr[i] = 1'b0;
        if (i_en[i] && i_op[i][4] && !illegal_req(i, i_exo[i], i_op[i])) begin
          sz  = int'(i_op[i][1:0]);
          nb  = 1 << sz;
          off = int'(i_exo[i][2:0]) & (nl - 1);
          m_addr[i] = {32'b0, i_exo[i][31:0]} >> ((i != 0) ? 3 : 2);
          m_as[i]   = 1'b0;
          m_rw[i]   = !i_op[i][3];
          m_be[i]   = 8'(((64'd1 << nl) - 1) & ~(((64'd1 << nb) - 1) << off));
          mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 1);
          v = '0;
          for (int k = 0; k < nl / nb; k++) v |= (i_wd[i] & mask) << (8 * nb * k);
          m_wr[i]   = v & dwmask(i);
          m_off[i]  = off; m_size[i] = sz; m_uns[i] = i_op[i][2];
          m_cnt[i]  = 0;
          m_ph[i]   = 1;
        end
      end
      1: begin
        if (!i_rdy[i]) begin
          m_ph[i] = 2; m_as[i] = 1'b1; m_be[i] = 8'((64'd1 << nl) - 1);
          if (m_rw[i]) begin
            nb = 1 << m_size[i];
            v  = i_rd[i] >> (8 * m_off[i]);
            if (nb < 8) begin
              mask = (64'd1 << (8 * nb)) - 1;
              v &= mask;
              if (!m_uns[i] && v[8 * nb - 1]) v |= ~mask;
            end
            m_load[i] = v & dwmask(i);
          end else begin
            m_load[i] = '0;
          end
        end else if (tmo(i) != 0 && m_cnt[i] == tmo(i) - 1) begin
          m_ph[i] = 2; m_as[i] = 1'b1; m_be[i] = 8'((64'd1 << nl) - 1);
          m_berr[i] = 1'b1; m_load[i] = '0;
        end else begin
          m_cnt[i]++;
        end
      end
      default: begin
        m_ph[i] = 0; m_berr[i] = 1'b0;
      end
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_);
      for (int i = 0; i < 2; i++) begin
        if (!reset_) model_reset(i);
        else model_step(i);
      end
    end
  end

  task automatic check_outputs(input int i);
    logic req, bad, e_mis, e_stall;
    logic [63:0] e_out;
    req = i_en[i] & i_op[i][4];
    bad = illegal_req(i, i_exo[i], i_op[i]);
    e_mis = 1'b0; e_stall = 1'b0; e_out = '0;
    case (m_ph[i])
      0: begin
        e_mis   = reset_ && req && bad;
        e_stall = reset_ && req && !bad;
        if (i_en[i] && !i_op[i][4]) e_out = i_exo[i] & dwmask(i);
      end
      1: e_stall = 1'b1;
      default: e_out = m_load[i];
    endcase
    chk("addr",       i, o_addr[i],      m_addr[i]);
    chk("as_",        i, 64'(o_as[i]),   64'(m_as[i]));
    chk("rw",         i, 64'(o_rw[i]),   64'(m_rw[i]));
    chk("be_",        i, 64'(o_be[i]),   64'(m_be[i]));
    chk("wr_data",    i, o_wr[i],        m_wr[i]);
    chk("out",        i, o_out[i],       e_out);
    chk("miss_align", i, 64'(o_mis[i]),  64'(e_mis));
    chk("bus_err",    i, 64'(o_berr[i]), 64'(m_berr[i]));
    chk("done",       i, 64'(o_done[i]), 64'(m_ph[i] == 2));
    chk("stall",      i, 64'(o_stall[i]),64'(e_stall));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        for (int i = 0; i < 2; i++) begin
          check_outputs(i);
          if (!o_as[i])   n_as[i]++;
          if (o_stall[i]) n_stall[i]++;
          if (o_done[i])  n_done[i]++;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [63:0] cap_addr, cap_wr, cap_out;
  logic [7:0]  cap_be;
  logic        cap_rw, cap_berr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input int i, input logic [4:0] op, input logic [63:0] a,
                        input logic [63:0] wd, input logic [63:0] rd, input int waits);
    bit got;
    got = 1'b0;
    n_as[i] = 0; n_stall[i] = 0; n_done[i] = 0;
    i_en[i] = 1'b1; i_op[i] = op; i_exo[i] = a; i_wd[i] = wd; i_rd[i] = rd; i_rdy[i] = 1'b1;
    for (int c = 0; c < 40 && !got; c++) begin
      tick();
      if (o_done[i]) begin
        got = 1'b1;
        cap_out = o_out[i]; cap_berr = o_berr[i];
        i_en[i] = 1'b0; i_rdy[i] = 1'b1;
      end else begin
        if (c == 0) begin
          cap_addr = o_addr[i]; cap_be = o_be[i]; cap_wr = o_wr[i]; cap_rw = o_rw[i];
        end
        i_rdy[i] = (c < waits);
      end
    end
    if (!got) chk("done_seen", i, 64'd0, 64'd1);
    i_en[i] = 1'b0; i_rdy[i] = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_ = 1'b0;
    for (int i = 0; i < 2; i++) begin
      i_en[i] = 1'b0; i_op[i] = '0; i_wd[i] = '0; i_exo[i] = '0; i_rd[i] = '0; i_rdy[i] = 1'b1;
      model_reset(i);
      n_as[i] = 0; n_stall[i] = 0; n_done[i] = 0;
    end
    tick();
    checking = 1'b1;
    chk("rst_as_", 0, 64'(a_as), 64'd1);
    chk("rst_be_", 1, 64'(b_be), 64'hFF);
    tick();
    reset_ = 1'b1;
    tick();

    // LB 0x1003, sign-extended
    access(0, 5'b10000, 64'h1003, 64'h0, 64'h8000_0000, 0);
    chk("lb_be_",   0, 64'(cap_be), 64'h07);
    chk("lb_addr",  0, cap_addr, 64'h400);
    chk("lb_out",   0, cap_out, 64'hFFFF_FF80);
    chk("lb_stall", 0, 64'(n_stall[0]), 64'd2);
    chk("lb_done",  0, 64'(n_done[0]), 64'd1);
    chk("lb_as",    0, 64'(n_as[0]), 64'd1);

    // LBU 0x1003, zero-extended
    access(0, 5'b10100, 64'h1003, 64'h0, 64'h8000_0000, 0);
    chk("lbu_out", 0, cap_out, 64'h80);

    // SH 0x2002 with 3 wait cycles; rdy_ wins over the timeout on the 4th
    access(0, 5'b11001, 64'h2002, 64'h0000_ABCD, 64'h0, 3);
    chk("sh_addr",  0, cap_addr, 64'h800);
    chk("sh_rw",    0, 64'(cap_rw), 64'd0);
    chk("sh_be_",   0, 64'(cap_be), 64'h03);
    chk("sh_wr",    0, cap_wr, 64'hABCD_ABCD);
    chk("sh_as",    0, 64'(n_as[0]), 64'd4);
    chk("sh_stall", 0, 64'(n_stall[0]), 64'd5);
    chk("sh_berr",  0, 64'(cap_berr), 64'd0);

    // misaligned LW and illegal size-3 on the 32-bit unit
    i_en[0] = 1'b1; i_op[0] = 5'b10010; i_exo[0] = 64'h1001;
    #1;
    chk("mis_lw",       0, 64'(a_mis), 64'd1);
    chk("mis_lw_stall", 0, 64'(a_stall), 64'd0);
    chk("mis_lw_out",   0, 64'(a_out), 64'd0);
    tick();
    chk("mis_lw_as_", 0, 64'(a_as), 64'd1);
    i_op[0] = 5'b10011; i_exo[0] = 64'h1000;
    #1;
    chk("mis_ld32", 0, 64'(a_mis), 64'd1);
    i_en[0] = 1'b0;
    tick();

    // timeout
    access(0, 5'b10010, 64'h1000, 64'h0, 64'h5555_5555, 100);
    chk("to_berr", 0, 64'(cap_berr), 64'd1);
    chk("to_as",   0, 64'(n_as[0]), 64'd4);
    chk("to_done", 0, 64'(n_done[0]), 64'd1);
    chk("to_out",  0, cap_out, 64'd0);

    // 64-bit unit
    access(1, 5'b10101, 64'h1006, 64'h0, 64'hBEEF_1122_3344_5566, 0);
    chk("lhu_be_", 1, 64'(cap_be), 64'h3F);
    chk("lhu_out", 1, cap_out, 64'h0000_0000_0000_BEEF);
    access(1, 5'b10001, 64'h1006, 64'h0, 64'hBEEF_1122_3344_5566, 1);
    chk("lh_out",  1, cap_out, 64'hFFFF_FFFF_FFFF_BEEF);
    access(1, 5'b11011, 64'h1008, 64'h0123_4567_89AB_CDEF, 64'h0, 2);
    chk("sd_be_",  1, 64'(cap_be), 64'h00);
    chk("sd_addr", 1, cap_addr, 64'h201);
    chk("sd_wr",   1, cap_wr, 64'h0123_4567_89AB_CDEF);
    access(1, 5'b10000, 64'h100D, 64'h0, 64'h0000_7F00_0000_0000, 0);
    chk("lb64_out", 1, cap_out, 64'h7F);

    // reset in the second ACCESS cycle
    i_en[0] = 1'b1; i_op[0] = 5'b10010; i_exo[0] = 64'h3000; i_wd[0] = 64'h1111_2222; i_rdy[0] = 1'b1;
    tick();
    tick();
    chk("pre_rst_as_", 0, 64'(a_as), 64'd0);
    #2 reset_ = 1'b0;
    #1;
    chk("arst_as_",   0, 64'(a_as), 64'd1);
    chk("arst_be_",   0, 64'(a_be), 64'h0F);
    chk("arst_addr",  0, 64'(a_addr), 64'd0);
    chk("arst_wr",    0, 64'(a_wr), 64'd0);
    chk("arst_rw",    0, 64'(a_rw), 64'd1);
    chk("arst_stall", 0, 64'(a_stall), 64'd0);
    chk("arst_done",  0, 64'(a_done), 64'd0);
    i_en[0] = 1'b0;
    tick();
    tick();
    reset_ = 1'b1;
    tick();
    access(0, 5'b10010, 64'h3000, 64'h0, 64'hDEAD_BEEF, 1);
    chk("post_rst_out", 0, cap_out, 64'hDEAD_BEEF);
    chk("post_rst_as",  0, 64'(n_as[0]), 64'd2);

    // non-memory pass-through; rdy_ low in IDLE must be ignored
    i_en[0] = 1'b1; i_op[0] = 5'b00000; i_exo[0] = 64'h1234; i_rdy[0] = 1'b0;
    #1;
    chk("nonmem_out",   0, 64'(a_out), 64'h1234);
    chk("nonmem_stall", 0, 64'(a_stall), 64'd0);
    tick();
    chk("nonmem_as_", 0, 64'(a_as), 64'd1);
    i_en[0] = 1'b0;
    #1;
    chk("idle_out", 0, 64'(a_out), 64'd0);
    i_rdy[0] = 1'b1;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
